// File: rtl/fft_pkg.sv
// fft_pkg: shared constants and types for the FFT frame sequencer.
//   FFT_N            points per frame
//   FFT_DW           default sample component width
//   FFT_LATENCY_DEF  default datapath latency in clocks
//   fft_seq_state_t  sequencer states LOAD / COMPUTE / UNLOAD
//   fft_idx_t        4-bit sample/bin index
package fft_pkg;
  localparam int FFT_N           = 16;
  localparam int FFT_DW          = 16;
  localparam int FFT_LATENCY_DEF = 64;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    UNLOAD  = 2'd2
  } fft_seq_state_t;

  typedef logic [3:0] fft_idx_t;
endpackage

// File: rtl/fft_frame_buffer.sv
// fft_frame_buffer: 16-entry complex register file.
//   clock, resetn         clock, async active-low reset (clears all entries)
//   i_wr_en/idx/x/y       serial write port
//   i_ld_en, i_ld_x/y     parallel load of all entries (wins over a write)
//   i_rd_idx, o_rd_x/y    serial read mux
//   o_flat_x/y            all entries flattened, entry k at [DW*k +: DW]
module fft_frame_buffer import fft_pkg::*; #(
  parameter int DW = FFT_DW
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                i_wr_en,
  input  fft_idx_t            i_wr_idx,
  input  logic [DW-1:0]       i_wr_x,
  input  logic [DW-1:0]       i_wr_y,
  input  logic                i_ld_en,
  input  logic [FFT_N*DW-1:0] i_ld_x,
  input  logic [FFT_N*DW-1:0] i_ld_y,
  input  fft_idx_t            i_rd_idx,
  output logic [DW-1:0]       o_rd_x,
  output logic [DW-1:0]       o_rd_y,
  output logic [FFT_N*DW-1:0] o_flat_x,
  output logic [FFT_N*DW-1:0] o_flat_y
);
  logic [FFT_N-1:0][DW-1:0] r_x, r_y;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_ld_en) begin
      r_x <= i_ld_x;
      r_y <= i_ld_y;
    end else if (i_wr_en) begin
      r_x[i_wr_idx] <= i_wr_x;
      r_y[i_wr_idx] <= i_wr_y;
    end
  end

  assign o_flat_x = r_x;
  assign o_flat_y = r_y;
  assign o_rd_x   = r_x[i_rd_idx];
  assign o_rd_y   = r_y[i_rd_idx];
endmodule

// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer: serial-to-parallel frame loader / parallel-to-serial
// unloader around a 16-point FFT datapath that has no valid signalling.
//   clock, resetn          clock, async active-low reset
//   in_valid/ready/x/y     input sample stream
//   out_valid/ready/x/y    output bin stream, out_idx = bin index
//   busy                   high while COMPUTE or UNLOAD
//   fft_xin/yin            parallel frame to datapath (sample k at [DW*k +: DW])
//   fft_xout/yout          parallel result from datapath
// Optional macro FFT_TLAST_EN adds in_last, out_last and frame_err framing.
module fft_frame_sequencer import fft_pkg::*; #(
  parameter int DW          = FFT_DW,
  parameter int FFT_LATENCY = FFT_LATENCY_DEF
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DW-1:0]       in_x,
  input  logic [DW-1:0]       in_y,
`ifdef FFT_TLAST_EN
  input  logic                in_last,
  output logic                out_last,
  output logic                frame_err,
`endif
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DW-1:0]       out_x,
  output logic [DW-1:0]       out_y,
  output fft_idx_t            out_idx,
  output logic                busy,
  output logic [FFT_N*DW-1:0] fft_xin,
  output logic [FFT_N*DW-1:0] fft_yin,
  input  logic [FFT_N*DW-1:0] fft_xout,
  input  logic [FFT_N*DW-1:0] fft_yout
);
  localparam int CW = $clog2(FFT_LATENCY + 1);

  fft_seq_state_t r_state;
  fft_idx_t       r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]  r_cnt;
  logic [DW-1:0]  r_out_x, r_out_y;

  logic           w_in_acc, w_out_acc, w_cnt_done, w_drop;
  logic [DW-1:0]  w_obuf_rd_x, w_obuf_rd_y;
  logic [DW-1:0]  w_ibuf_rd_x_unused, w_ibuf_rd_y_unused;
  logic [FFT_N*DW-1:0] w_obuf_flat_x_unused, w_obuf_flat_y_unused;

  assign w_in_acc   = in_valid & in_ready;
  assign w_out_acc  = out_valid & out_ready;
  assign w_cnt_done = (r_state == COMPUTE) && (r_cnt == CW'(FFT_LATENCY));

`ifdef FFT_TLAST_EN
  // Early in_last abandons the partial frame.
  assign w_drop = w_in_acc & in_last & (r_wr_ptr != 4'd15);
`else
  assign w_drop = 1'b0;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state  <= LOAD;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_out_x  <= '0;
      r_out_y  <= '0;
    end else begin
      case (r_state)
        LOAD: begin
          if (w_drop) begin
            r_wr_ptr <= '0;
          end else if (w_in_acc) begin
            r_wr_ptr <= r_wr_ptr + 4'd1;
            if (r_wr_ptr == 4'd15) begin
              r_state <= COMPUTE;
              r_cnt   <= '0;
            end
          end
        end
        COMPUTE: begin
          if (w_cnt_done) begin
            // Bin 0 goes straight into the output register so out_x/out_y
            // are valid in the first UNLOAD cycle.
            r_state  <= UNLOAD;
            r_cnt    <= '0;
            r_rd_ptr <= '0;
            r_out_x  <= fft_xout[DW-1:0];
            r_out_y  <= fft_yout[DW-1:0];
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        UNLOAD: begin
          if (w_out_acc) begin
            r_rd_ptr <= r_rd_ptr + 4'd1;
            if (r_rd_ptr == 4'd15) begin
              r_state <= LOAD;
              r_out_x <= '0;
              r_out_y <= '0;
            end else begin
              // obuf read port is addressed one ahead of rd_ptr.
              r_out_x <= w_obuf_rd_x;
              r_out_y <= w_obuf_rd_y;
            end
          end
        end
        default: r_state <= LOAD;
      endcase
    end
  end

`ifdef FFT_TLAST_EN
  logic r_out_last, r_frame_err;
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_out_last  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      // Error when in_last disagrees with the 16-count framing.
      r_frame_err <= w_in_acc & ((r_wr_ptr == 4'd15) ? ~in_last : in_last);
      if (w_cnt_done)
        r_out_last <= 1'b0;
      else if (w_out_acc)
        r_out_last <= (r_rd_ptr == 4'd14);
    end
  end
  assign out_last  = r_out_last;
  assign frame_err = r_frame_err;
`endif

  fft_frame_buffer #(.DW(DW)) u_ibuf (
    .clock    (clock),
    .resetn   (resetn),
    .i_wr_en  (w_in_acc),
    .i_wr_idx (r_wr_ptr),
    .i_wr_x   (in_x),
    .i_wr_y   (in_y),
    .i_ld_en  (1'b0),
    .i_ld_x   ('0),
    .i_ld_y   ('0),
    .i_rd_idx (r_wr_ptr),
    .o_rd_x   (w_ibuf_rd_x_unused),
    .o_rd_y   (w_ibuf_rd_y_unused),
    .o_flat_x (fft_xin),
    .o_flat_y (fft_yin)
  );

  fft_frame_buffer #(.DW(DW)) u_obuf (
    .clock    (clock),
    .resetn   (resetn),
    .i_wr_en  (1'b0),
    .i_wr_idx ('0),
    .i_wr_x   ('0),
    .i_wr_y   ('0),
    .i_ld_en  (w_cnt_done),
    .i_ld_x   (fft_xout),
    .i_ld_y   (fft_yout),
    .i_rd_idx (r_rd_ptr + 4'd1),
    .o_rd_x   (w_obuf_rd_x),
    .o_rd_y   (w_obuf_rd_y),
    .o_flat_x (w_obuf_flat_x_unused),
    .o_flat_y (w_obuf_flat_y_unused)
  );

  assign in_ready  = (r_state == LOAD);
  assign out_valid = (r_state == UNLOAD);
  assign busy      = (r_state != LOAD);
  assign out_x     = r_out_x;
  assign out_y     = r_out_y;
  assign out_idx   = r_rd_ptr;
endmodule

// File: tb/tb_fft_frame_sequencer.sv
module tb_fft_frame_sequencer;
  import fft_pkg::*;
  localparam int DW  = 16;
  localparam int LAT = 64;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, busy;
  logic [DW-1:0] in_x = '0, in_y = '0, out_x, out_y;
  fft_idx_t out_idx;
  logic [16*DW-1:0] fft_xin, fft_yin, fft_xout, fft_yout;
`ifdef FFT_TLAST_EN
  logic in_last = 1'b0, out_last, frame_err;
`endif

  fft_frame_sequencer #(.DW(DW), .FFT_LATENCY(LAT)) dut (
    .clock(clock), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
`ifdef FFT_TLAST_EN
    .in_last(in_last), .out_last(out_last), .frame_err(frame_err),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
    .out_idx(out_idx), .busy(busy),
    .fft_xin(fft_xin), .fft_yin(fft_yin), .fft_xout(fft_xout), .fft_yout(fft_yout)
  );

  // Stub datapath: LAT-stage identity delay line.
  logic [16*DW-1:0] dx [LAT];
  logic [16*DW-1:0] dy [LAT];
  always @(posedge clock) begin
    dx[0] <= fft_xin;
    dy[0] <= fft_yin;
    for (int i = 1; i < LAT; i++) begin
      dx[i] <= dx[i-1];
      dy[i] <= dy[i-1];
    end
  end
  assign fft_xout = dx[LAT-1];
  assign fft_yout = dy[LAT-1];

  typedef struct { logic [DW-1:0] x; logic [DW-1:0] y; } smp_t;
  typedef struct { logic [DW-1:0] x; logic [DW-1:0] y; logic [DW-1:0] ex; logic [DW-1:0] ey; } vec_t;

  int n_pass = 0, n_chk = 0;
  int out_total = 0;
  int pos = 0;
  smp_t in_q[$], exp_q[$];
  smp_t e_m;
  logic stall = 1'b0;
  logic [DW-1:0] hx, hy;
  fft_idx_t hi;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  // Reference model: frames of 16 accepted samples reappear in order,
  // bin index counts 0..15 per frame; stalled outputs must hold.
  always @(negedge clock) begin
    if (!resetn) begin
      in_q.delete(); exp_q.delete(); pos = 0; stall = 1'b0;
    end else begin
      if (stall && out_valid) begin
        chk("hold_x", out_x, hx);
        chk("hold_y", out_y, hy);
        chk("hold_idx", out_idx, hi);
      end
      stall = out_valid && !out_ready;
      hx = out_x; hy = out_y; hi = out_idx;
      if (in_valid && in_ready) begin
`ifdef FFT_TLAST_EN
        if (in_last && in_q.size() != 15) in_q.delete(); else
`endif
        begin
          in_q.push_back('{x: in_x, y: in_y});
          if (in_q.size() == 16) begin
            exp_q = {exp_q, in_q};
            in_q.delete();
          end
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
        else begin
          e_m = exp_q.pop_front();
          chk("out_x", out_x, e_m.x);
          chk("out_y", out_y, e_m.y);
          chk("out_idx", out_idx, pos);
`ifdef FFT_TLAST_EN
          chk("out_last", out_last, (pos == 15));
`endif
        end
        pos = (pos + 1) % 16;
        out_total++;
      end
    end
  end

  task automatic cyc();
    @(posedge clock); #1;
  endtask

  task automatic send(input smp_t s);
    int n = 0;
    logic acc;
    in_valid = 1'b1; in_x = s.x; in_y = s.y;
    do begin acc = in_ready; cyc(); n++; end while (!acc && n < 500);
    if (!acc) chk("in_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  // mode 0: always ready, 1: toggle 1,0,1,0, 2: random
  task automatic drain(input int mode);
    int tgt = out_total + 16;
    int n = 0;
    while (out_total < tgt && n < 3000) begin
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = (n % 2 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      cyc(); n++;
    end
    if (out_total < tgt) chk("drain_timeout", 0, 1);
    chk("in_ready_after_frame", in_ready, 1);
    chk("out_valid_after_frame", out_valid, 0);
    out_ready = 1'b0;
  endtask

  vec_t tbl [16];
  smp_t s;
  int n, idx, c;
  logic acc;

  initial begin
    for (int k = 0; k < 16; k++) begin
      tbl[k].x  = (k % 2 == 0) ? 16'h7FFF : 16'h8000;
      tbl[k].y  = (k % 2 == 0) ? 16'h8000 : 16'h7FFF;
      tbl[k].ex = (k % 2 == 0) ? 16'h7FFF : 16'h8000;
      tbl[k].ey = (k % 2 == 0) ? 16'h8000 : 16'h7FFF;
    end

    // 1. reset
    resetn = 1'b0;
    repeat (3) cyc();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_x", out_x, 0);
    chk("rst_out_y", out_y, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_fft_in_zero", (fft_xin == '0) && (fft_yin == '0), 1);
    resetn = 1'b1;
    cyc();
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_busy", busy, 0);

    // 2. back-to-back ramp, latency
    for (int k = 0; k < 16; k++) begin
      s.x = 16'(k); s.y = 16'(-k);
      send(s);
    end
    chk("in_ready_after_16", in_ready, 0);
    chk("busy_compute", busy, 1);
    n = 0;
    while (!out_valid && n < 300) begin cyc(); n++; end
    chk("latency_cycles", n, LAT + 1);
    drain(0);

    // 3. backpressure toggling
    for (int k = 0; k < 16; k++) begin
      s.x = 16'(100 + k); s.y = 16'(16'hF000 + k);
      send(s);
    end
    drain(1);

    // 4. input bubbles 1,0,0,1; check placement on the datapath bus
    idx = 0; c = 0;
    while (idx < 16 && c < 500) begin
      acc = 1'b0;
      if (c % 4 == 0 || c % 4 == 3) begin
        in_valid = 1'b1; in_x = tbl[idx].x; in_y = tbl[idx].y; acc = in_ready;
      end else in_valid = 1'b0;
      cyc();
      if (acc) idx++;
      c++;
    end
    in_valid = 1'b0;
    chk("bubble_all_loaded", idx, 16);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("xin_slice%0d", k), fft_xin[DW*k +: DW], tbl[k].ex);
      chk($sformatf("yin_slice%0d", k), fft_yin[DW*k +: DW], tbl[k].ey);
    end
    drain(0);

    // 5. reset in the middle of UNLOAD
    for (int k = 0; k < 16; k++) begin
      s.x = 16'(3 * k + 7); s.y = 16'(5 * k + 1);
      send(s);
    end
    n = 0;
    while (!out_valid && n < 300) begin cyc(); n++; end
    out_ready = 1'b1;
    repeat (5) cyc();
    out_ready = 1'b0;
    chk("mid_idx_before_reset", out_idx, 5);
    resetn = 1'b0;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_in_ready", in_ready, 1);
    chk("async_rst_out_idx", out_idx, 0);
    chk("async_rst_busy", busy, 0);
    repeat (2) cyc();
    resetn = 1'b1;
    cyc();
    for (int k = 0; k < 16; k++) begin
      s.x = 16'(16'h1234 ^ k); s.y = 16'(k << 8);
      send(s);
    end
    drain(0);

    // random frames, random bubbles and backpressure
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 16; k++) begin
        repeat ($urandom_range(0, 2)) cyc();
        s.x = 16'($urandom); s.y = 16'($urandom);
        send(s);
      end
      drain(2);
    end

`ifdef FFT_TLAST_EN
    // 6a. early in_last on sample 10 -> error, frame dropped
    for (int k = 0; k < 10; k++) begin
      in_last = (k == 9);
      s.x = 16'(k + 50); s.y = 16'(k + 60);
      send(s);
    end
    in_last = 1'b0;
    chk("early_last_err", frame_err, 1);
    chk("early_last_in_ready", in_ready, 1);
    chk("early_last_busy", busy, 0);
    cyc();
    chk("early_last_err_pulse", frame_err, 0);
    // 6b. correct frame
    for (int k = 0; k < 16; k++) begin
      in_last = (k == 15);
      s.x = 16'(k * 9); s.y = 16'(k * 11);
      send(s);
    end
    in_last = 1'b0;
    chk("good_frame_no_err", frame_err, 0);
    drain(0);
    chk("no_extra_frame", exp_q.size(), 0);
    // 6c. missing in_last on bin 15 -> error but processed
    for (int k = 0; k < 16; k++) begin
      s.x = 16'(k + 200); s.y = 16'(k + 300);
      send(s);
    end
    chk("missing_last_err", frame_err, 1);
    drain(0);
`endif

    chk("model_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_chk);
    $fatal(1);
  end
endmodule
